scale_mux_arb: RTL

//   N-channel, SIZE-bit registered multiplexer with valid/ready handshakes and

---
 rtl/scale_mux_pkg.sv | 21 ++
 rtl/scale_rr_arb.sv | 23 ++
 rtl/scale_mux_arb.sv | 73 +++++++
 3 files changed

// File: rtl/scale_mux_pkg.sv
// scale_mux_pkg: shared types and round-robin search helper for scale_mux_arb
package scale_mux_pkg;

   typedef enum logic {EMPTY, FULL} out_state_t;

   localparam int MAX_CHANNELS = 64;

   // Returns the first requesting index after ptr, wrapping at n; -1 if none
   function automatic int rr_next(input int ptr, input logic [MAX_CHANNELS-1:0] req, input int n);
      int res;
      int i;
      res = -1;
      for (int k = 1; k <= n; k++) begin
         i = ptr + k;
         if (i >= n) i = i - n;
         if (res < 0 && req[i]) res = i;
      end
      return res;
   endfunction

endpackage

// File: rtl/scale_rr_arb.sv
// scale_rr_arb: combinational round-robin arbiter, search starts just above PTR
module scale_rr_arb
   import scale_mux_pkg::*;
#(
   parameter int CHANNELS = 2,
   localparam int SEL_W = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] REQ,
   input  logic [SEL_W-1:0]    PTR,
   output logic [CHANNELS-1:0] GNT,
   output logic [SEL_W-1:0]    GNT_IDX
);

   int idx;

   // One-hot grant plus its index; no request means no grant
   always_comb begin
      idx = rr_next(int'(PTR), MAX_CHANNELS'(REQ), CHANNELS);
      GNT = (idx >= 0) ? CHANNELS'(1) << idx : '0;
      GNT_IDX = (idx >= 0) ? SEL_W'(idx) : '0;
   end

endmodule

// File: rtl/scale_mux_arb.sv
// scale_mux_arb: N-channel registered mux with valid/ready and round-robin arbitration
// Optional SCALE_MUX_FORCE_EN adds FORCE/SEL to override the arbiter.
module scale_mux_arb
   import scale_mux_pkg::*;
#(
   parameter int SIZE = 1,
   parameter int CHANNELS = 2,
   localparam int SEL_W = $clog2(CHANNELS)
) (
`ifdef SCALE_MUX_FORCE_EN
   input  logic                     FORCE,
   input  logic [SEL_W-1:0]         SEL,
`endif
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [CHANNELS*SIZE-1:0] IN_DATA,
   input  logic [CHANNELS-1:0]      IN_VALID,
   output logic [CHANNELS-1:0]      IN_READY,
   output logic [SIZE-1:0]          OUT,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [SEL_W-1:0]         OUT_SEL
);

   out_state_t state;
   logic [SEL_W-1:0] ptr, rr_idx, gidx;
   logic [CHANNELS-1:0] rr_gnt, gnt;
   logic load, any, upd_ptr;

   scale_rr_arb #(.CHANNELS(CHANNELS)) u_arb (
      .REQ(IN_VALID),
      .PTR(ptr),
      .GNT(rr_gnt),
      .GNT_IDX(rr_idx)
   );

`ifdef SCALE_MUX_FORCE_EN
   logic force_ok;
   assign force_ok = FORCE && (32'(SEL) < CHANNELS) && IN_VALID[SEL];
   assign gnt = FORCE ? (force_ok ? CHANNELS'(1) << SEL : '0) : rr_gnt;
   assign gidx = FORCE ? SEL : rr_idx;
   assign upd_ptr = ~FORCE;
`else
   assign gnt = rr_gnt;
   assign gidx = rr_idx;
   assign upd_ptr = 1'b1;
`endif

   assign load = (state == EMPTY) | OUT_READY;
   assign any = |gnt;
   assign IN_READY = gnt & {CHANNELS{load & ~RST}};
   assign OUT_VALID = (state == FULL);

   // Output stage: load the granted word, drain to EMPTY when nothing is granted
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= EMPTY;
         OUT <= '0;
         OUT_SEL <= '0;
         ptr <= SEL_W'(CHANNELS - 1);
      end else if (load) begin
         if (any) begin
            state <= FULL;
            OUT <= IN_DATA[gidx*SIZE +: SIZE];
            OUT_SEL <= gidx;
            if (upd_ptr) ptr <= gidx;
         end else begin
            state <= EMPTY;
         end
      end
   end

endmodule
